// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: target FSM states, R/W bit encoding,
// default device ID and bit-counter constants.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        WAIT_STOP
    } sccb_state_e;

    localparam logic       SCCB_WRITE      = 1'b0;
    localparam logic       SCCB_READ       = 1'b1;
    localparam logic [6:0] SCCB_DEFAULT_ID = 7'h21;

    // Bit counter value after the 8th data rise; the ACK slot follows it.
    localparam logic [3:0] BIT_ACK = 4'd8;

endpackage

// File: rtl/sccb_target_if.sv
// SCCB target bus + register-file request bundle.
//   sio_c, sio_d_in : SCCB pins as seen by the target (asynchronous)
//   sio_d_oe        : 1 = target pulls SIO_D low
//   reg_*           : register-file request side (addr, wdata, we, rd, rdata)
//   busy            : transaction addressed to this target is in progress
interface sccb_target_if;
    logic       sio_c;
    logic       sio_d_in;
    logic       sio_d_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  sio_c, sio_d_in, reg_rdata,
        output sio_d_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy
    );

    modport master (
        output sio_c, sio_d_in, reg_rdata,
        input  sio_d_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy
    );
endinterface

// File: rtl/sccb_bus_sync.sv
// SCCB line synchronizer and event detector.
//   i_scl, i_sda  : raw asynchronous SIO_C / SIO_D
//   o_sda         : synchronized SIO_D level
//   o_scl_rise/fall, o_start, o_stop : one-cycle event pulses
// Synchronizers and history flops reset to 1 (idle bus is high).
module sccb_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    assign o_sda      = w_sda;
    assign o_scl_rise =  w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl &  r_scl_d;
    // SIO_C must be high both now and one cycle ago so an SDA change that
    // races an SCL edge is never taken as START/STOP.
    assign o_start    = w_scl & r_scl_d & ~w_sda &  r_sda_d;
    assign o_stop     = w_scl & r_scl_d &  w_sda & ~r_sda_d;

endmodule

// File: rtl/sccb_target.sv
// SCCB target (camera side) with a simple register-file request port.
//   clk, resetn : system clock (>= 20x SIO_C), synchronous active-low reset
//   bus         : sccb_target_if.slave (SCCB pins, reg_* requests, busy)
// Decodes 3-phase writes (ID, SUB, DATA) and 2-phase reads (ID, DATA).
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEVICE_ID   = SCCB_DEFAULT_ID,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          resetn,
    sccb_target_if.slave  bus
);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    sccb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .resetn     (resetn),
        .i_scl      (bus.sio_c),
        .i_sda      (bus.sio_d_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    sccb_state_e r_state, state_n;
    logic [3:0]  r_bitcnt, bitcnt_n;
    logic [7:0]  r_shift, shift_n;
    logic [7:0]  r_addr, addr_n;
    logic [7:0]  r_wdata, wdata_n;
    logic        r_oe, oe_n;
    logic        r_busy, busy_n;
    logic        r_rw, rw_n;
    logic        r_we, we_n;
    logic        r_rd, rd_n;
    logic        r_rd_d;

    assign w_byte = {r_shift[6:0], w_sda};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
            r_rw     <= SCCB_WRITE;
            r_we     <= 1'b0;
            r_rd     <= 1'b0;
            r_rd_d   <= 1'b0;
        end else begin
            r_state  <= state_n;
            r_bitcnt <= bitcnt_n;
            r_shift  <= shift_n;
            r_addr   <= addr_n;
            r_wdata  <= wdata_n;
            r_oe     <= oe_n;
            r_busy   <= busy_n;
            r_rw     <= rw_n;
            r_we     <= we_n;
            r_rd     <= rd_n;
            r_rd_d   <= r_rd;
        end
    end

    always_comb begin
        state_n  = r_state;
        bitcnt_n = r_bitcnt;
        shift_n  = r_shift;
        addr_n   = r_addr;
        wdata_n  = r_wdata;
        oe_n     = r_oe;
        busy_n   = r_busy;
        rw_n     = r_rw;
        we_n     = 1'b0;
        rd_n     = 1'b0;

        if (w_stop) begin
            state_n  = IDLE;
            bitcnt_n = '0;
            oe_n     = 1'b0;
            busy_n   = 1'b0;
        end else if (w_start) begin
            state_n  = ID;
            bitcnt_n = '0;
            oe_n     = 1'b0;
        end else begin
            case (r_state)
                ID, SUB, WDATA: begin
                    if (w_scl_rise) begin
                        shift_n  = w_byte;
                        bitcnt_n = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            if (r_state == ID) begin
                                if (w_byte[7:1] == DEVICE_ID) begin
                                    busy_n  = 1'b1;
                                    rw_n    = w_byte[0];
                                    rd_n    = (w_byte[0] == SCCB_READ);
                                    state_n = ID_ACK;
                                end else begin
                                    state_n = WAIT_STOP;
                                end
                            end else if (r_state == SUB) begin
                                addr_n  = w_byte;
                                state_n = SUB_ACK;
                            end else begin
                                wdata_n = w_byte;
                                we_n    = 1'b1;
                                state_n = WDATA_ACK;
                            end
                        end
                    end
                end
                // Counter sits at BIT_ACK on entry: the first fall pulls SDA
                // low, the 9th rise wraps it to 0, the next fall ends the slot.
                ID_ACK, SUB_ACK, WDATA_ACK: begin
                    if (w_scl_rise)
                        bitcnt_n = (r_bitcnt == BIT_ACK) ? 4'd0 : r_bitcnt + 4'd1;
                    if (w_scl_fall) begin
                        if (r_bitcnt == BIT_ACK) begin
                            oe_n = 1'b1;
                        end else if (r_bitcnt == 4'd0) begin
                            oe_n = 1'b0;
                            case (r_state)
                                ID_ACK: begin
                                    if (r_rw == SCCB_READ) begin
                                        oe_n    = ~r_shift[7];
                                        state_n = RDATA;
                                    end else begin
                                        state_n = SUB;
                                    end
                                end
                                SUB_ACK: state_n = WDATA;
                                default: state_n = WAIT_STOP;
                            endcase
                        end
                    end
                end
                // Bit 7 already on the line; shift the rest out MSB first,
                // release at the 8th fall, ignore the master's ACK/NA.
                RDATA: begin
                    if (w_scl_rise) begin
                        if (r_bitcnt == BIT_ACK) begin
                            bitcnt_n = '0;
                            state_n  = WAIT_STOP;
                        end else begin
                            bitcnt_n = r_bitcnt + 4'd1;
                        end
                    end
                    if (w_scl_fall) begin
                        if (r_bitcnt == BIT_ACK) begin
                            oe_n = 1'b0;
                        end else if (r_bitcnt != 4'd0) begin
                            oe_n    = ~r_shift[6];
                            shift_n = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                IDLE, WAIT_STOP: ;
                default: state_n = IDLE;
            endcase
        end

        // Register file answers the cycle after reg_rd.
        if (r_rd_d)
            shift_n = bus.reg_rdata;
    end

    assign bus.sio_d_oe  = r_oe;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_we    = r_we;
    assign bus.reg_rd    = r_rd;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: a behavioural SCCB master drives the pins through
// an open-drain wired-AND; a register-file model answers reads. Expected
// results come from a transaction-level model (memory array + current
// address pointer).
module tb_sccb_target;

    localparam int Q = 80;   // quarter SIO_C period in ns (clk = 10 ns)

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic m_scl  = 1'b1;
    logic m_sda  = 1'b1;

    always #5 clk = ~clk;

    sccb_target_if bus();

    logic [7:0] mem [256];
    logic [7:0] model_addr;

    assign bus.sio_c     = m_scl;
    assign bus.sio_d_in  = m_sda & ~bus.sio_d_oe;
    assign bus.reg_rdata = mem[bus.reg_addr];

    sccb_target #(.DEVICE_ID(7'h21), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Monotonic event monitors; the stimulus takes before/after snapshots.
    int         we_cnt = 0, rd_cnt = 0, oe_cyc = 0, busy_cyc = 0;
    logic [7:0] we_addr = '0, we_data = '0, rd_addr = '0;

    always @(negedge clk) begin
        if (bus.reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bus.reg_addr;
            we_data <= bus.reg_wdata;
        end
        if (bus.reg_rd) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= bus.reg_addr;
        end
        if (bus.sio_d_oe) oe_cyc   <= oe_cyc + 1;
        if (bus.busy)     busy_cyc <= busy_cyc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SCCB master ----------------
    task automatic m_bit(input logic b);
        m_sda = b; #Q;
        m_scl = 1'b1; #(2*Q);
        m_scl = 1'b0; #Q;
    endtask

    task automatic m_ack(output logic ack);
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        ack = ~bus.sio_d_in; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic m_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit(b[i]);
        m_ack(ack);
    endtask

    task automatic m_rbyte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; #Q;
            m_scl = 1'b1; #Q;
            b[i] = bus.sio_d_in; #Q;
            m_scl = 1'b0; #Q;
        end
        m_bit(nack);
    endtask

    task automatic m_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic m_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
        repeat (6) @(negedge clk);
    endtask

    // ---------------- transactions + model ----------------
    task automatic do_write3(input logic [7:0] id, input logic [7:0] sub,
                             input logic [7:0] dat, input logic extra, input string tag);
        int   we0, rd0, oe0;
        logic a0, a1, a2, a3, hit;
        hit = (id[7:1] == 7'h21) && !id[0];
        we0 = we_cnt; rd0 = rd_cnt; oe0 = oe_cyc;
        m_start();
        m_byte(id, a0);
        chk({tag, ".busy"}, bus.busy, hit);
        m_byte(sub, a1);
        m_byte(dat, a2);
        if (extra) begin
            m_byte(8'h5A, a3);
            chk({tag, ".extra_ack"}, a3, 1'b0);
        end
        m_stop();
        chk({tag, ".ack_id"},  a0, hit);
        chk({tag, ".ack_sub"}, a1, hit);
        chk({tag, ".ack_dat"}, a2, hit);
        chk({tag, ".we_cnt"},  we_cnt - we0, hit ? 1 : 0);
        chk({tag, ".rd_cnt"},  rd_cnt - rd0, 0);
        chk({tag, ".busy_end"}, bus.busy, 1'b0);
        if (hit) begin
            chk({tag, ".we_addr"}, we_addr, sub);
            chk({tag, ".we_data"}, we_data, dat);
            model_addr = sub;
            mem[sub]   = dat;
        end else begin
            chk({tag, ".oe_cyc"}, oe_cyc - oe0, 0);
        end
        chk({tag, ".reg_addr"}, bus.reg_addr, model_addr);
    endtask

    task automatic do_write2(input logic [7:0] sub, input string tag);
        int   we0;
        logic a0, a1;
        we0 = we_cnt;
        m_start();
        m_byte(8'h42, a0);
        m_byte(sub, a1);
        m_stop();
        model_addr = sub;
        chk({tag, ".ack_id"},   a0, 1'b1);
        chk({tag, ".ack_sub"},  a1, 1'b1);
        chk({tag, ".we_cnt"},   we_cnt - we0, 0);
        chk({tag, ".reg_addr"}, bus.reg_addr, model_addr);
    endtask

    task automatic do_read(input string tag);
        int         we0, rd0;
        logic       a0;
        logic [7:0] d;
        we0 = we_cnt; rd0 = rd_cnt;
        m_start();
        m_byte(8'h43, a0);
        m_rbyte(1'b1, d);
        m_stop();
        chk({tag, ".ack_id"},   a0, 1'b1);
        chk({tag, ".data"},     d, mem[model_addr]);
        chk({tag, ".rd_cnt"},   rd_cnt - rd0, 1);
        chk({tag, ".rd_addr"},  rd_addr, model_addr);
        chk({tag, ".we_cnt"},   we_cnt - we0, 0);
        chk({tag, ".busy_end"}, bus.busy, 1'b0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] id;
        int         we0, busy0;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        model_addr = 8'h00;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst.oe",    bus.sio_d_oe, 1'b0);
        chk("rst.busy",  bus.busy, 1'b0);
        chk("rst.we",    bus.reg_we, 1'b0);
        chk("rst.rd",    bus.reg_rd, 1'b0);
        chk("rst.addr",  bus.reg_addr, 8'h00);
        chk("rst.wdata", bus.reg_wdata, 8'h00);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Basic 3-phase write, then extra byte after the data is not ACKed
        do_write3(8'h42, 8'h12, 8'h80, 1'b0, "wr");
        do_write3(8'h42, 8'h20, 8'h3C, 1'b1, "wr_extra");

        // 2-phase address set, then read
        mem[8'h0A] = 8'h76;
        do_write2(8'h0A, "wr2");
        do_read("rd");

        // Wrong ID
        busy0 = busy_cyc;
        do_write3(8'h60, 8'h12, 8'h80, 1'b0, "badid");
        chk("badid.busy_cyc", busy_cyc - busy0, 0);

        // STOP after 4 bits of the data byte
        we0 = we_cnt;
        m_start();
        m_byte(8'h42, ack);
        m_byte(8'h12, ack);
        m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b1);
        m_stop();
        model_addr = 8'h12;
        chk("partial.we_cnt", we_cnt - we0, 0);
        chk("partial.busy",   bus.busy, 1'b0);
        chk("partial.addr",   bus.reg_addr, model_addr);

        // Reset pulse while the target holds the ID ACK
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(id_w(i));
        m_sda = 1'b1; #Q;
        chk("rstack.oe_before", bus.sio_d_oe, 1'b1);
        @(negedge clk) resetn = 1'b0;
        @(negedge clk);
        chk("rstack.oe_after", bus.sio_d_oe, 1'b0);
        chk("rstack.busy",     bus.busy, 1'b0);
        chk("rstack.addr",     bus.reg_addr, 8'h00);
        resetn = 1'b1;
        model_addr = 8'h00;
        repeat (4) @(negedge clk);
        do_write3(8'h42, 8'h05, 8'hAA, 1'b0, "post_rst");

        // Repeated START in the middle of the sub-address byte
        m_start();
        m_byte(8'h42, ack);
        m_bit(1'b1); m_bit(1'b1); m_bit(1'b0);
        do_write3(8'h42, 8'h33, 8'h01, 1'b0, "rstart");

        // Randomized transaction mix
        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 3))
                0: do_write3(8'h42, 8'($urandom), 8'($urandom), 1'($urandom), "rnd_wr");
                1: do_write2(8'($urandom), "rnd_wr2");
                2: do_read("rnd_rd");
                default: begin
                    do begin
                        id = 8'($urandom);
                    end while (id[7:1] == 7'h21);
                    do_write3(id, 8'($urandom), 8'($urandom), 1'b0, "rnd_bad");
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Bits of the write ID 0x42, indexed MSB..LSB.
    function automatic logic id_w(input int i);
        logic [7:0] b;
        b = 8'h42;
        return b[i];
    endfunction

endmodule
